data_memory: RTL
================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request capture to MFC assertion (legal 1..15).
REQ-002 SHALL have port CLK  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-004 SHALL have port Enable  input  1  active-low memory operation request (0 = request).
REQ-005 SHALL have port RW  input  1  1 = write, 0 = read.
REQ-006 SHALL have port Size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 SHALL have port Address  input  8  byte address into the 256-byte store.
REQ-008 SHALL have port DataIn  input  32  write data; byte/halfword taken from low bits.
REQ-009 SHALL have port DataOut  output  32  read data, registered.
REQ-010 SHALL have port MFC  output  1  memory function complete, registered, feeds the control unit.

Function
REQ-011 SHALL implement 256 bytes of storage, big-endian: word at A = {M[A],M[A+1],M[A+2],M[A+3]}.
REQ-012 SHALL force alignment: halfword ignores Address[0]; word ignores Address[1:0].
REQ-013 SHALL run FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 IDLE: on Enable=0, capture RW, Size, Address, DataIn; load counter with LATENCY-1; go BUSY.
REQ-015 BUSY: decrement counter each cycle; at counter=0 perform access and go DONE; request inputs ignored while BUSY.
REQ-016 Write SHALL update only the bytes selected by Size; other bytes unchanged; DataOut unchanged.
REQ-017 Read SHALL load DataOut zero-extended: byte -> {24'b0,M[A]}, halfword -> {16'b0,M[A],M[A+1]}, word -> full.
REQ-018 Size=11 SHALL complete the handshake with no store update and DataOut=0.
REQ-019 DONE: MFC=1; hold DONE and MFC while Enable=0; on Enable=1 go IDLE with MFC=0 next cycle.
REQ-020 MFC SHALL be 0 in IDLE and BUSY; MFC rises exactly LATENCY cycles after the edge that captured the request.
REQ-021 A new request SHALL be accepted only after returning to IDLE (Enable must go high for at least one cycle between operations).
REQ-022 Address arithmetic SHALL wrap modulo 256 (cannot occur with forced alignment; stated for completeness).
REQ-023 DataOut SHALL hold its last value until the next completed read or reset.

Reset
REQ-024 Reset=1 SHALL force state IDLE, MFC=0, DataOut=0, counter=0 on the next rising edge, overriding any request.
REQ-025 Reset during BUSY SHALL abort the operation; an uncommitted write SHALL not modify storage.
REQ-026 Reset SHALL NOT clear storage contents; contents after power-up are undefined unless preloaded.
REQ-027 Enable=0 held through Reset deassertion SHALL be treated as a new request on the first non-reset edge.

Verification
REQ-028 Reset=1 one cycle with Enable=0 -> MFC=0, DataOut=0, no write occurs.
REQ-029 Write word 32'hDEADBEEF at 8'h10, then read word 8'h10 -> MFC high at cycle 2 after capture each time, DataOut=32'hDEADBEEF; byte read 8'h11 -> 32'h000000AD.
REQ-030 Write byte 8'h5A at 8'h13 over previous word, read word 8'h12 -> 32'hDEADBE5A; halfword read 8'h13 (aligned to 8'h12) -> 32'h0000BE5A.
REQ-031 Hold Enable=0 for 6 cycles after MFC -> MFC stays 1, single write only; Enable=1 -> MFC=0 next cycle, state IDLE.
REQ-032 Issue write word 32'h12345678 at 8'h20, assert Reset in BUSY -> MFC never asserts, subsequent read of 8'h20 returns prior contents.
REQ-033 LATENCY=1 and LATENCY=4 builds: read -> MFC asserted 1 and 4 cycles after capture respectively; Size=11 -> MFC asserted, DataOut=0.

Source files
------------

// File: rtl/data_memory.sv
// 256-byte big-endian data memory with a fixed-latency IDLE/BUSY/DONE handshake.
// Storage is split into four byte lanes indexed by Address[7:2]; aligned accesses map onto whole lanes.

module data_memory_lane #(
   parameter int unsigned IDX_W = 6,
   parameter int unsigned VEC_W = 8
) (
   input  logic             CLK,
   input  logic             we,
   input  logic [IDX_W-1:0] idx,
   input  logic [VEC_W-1:0] wd,
   output logic [VEC_W-1:0] rd
);
   logic [VEC_W-1:0] mem [0:(1<<IDX_W)-1];

   // Storage is deliberately not reset; contents survive Reset.
   always_ff @(posedge CLK) begin
      if (we) mem[idx] <= wd;
   end

   assign rd = mem[idx];
endmodule

module data_memory #(
   parameter int unsigned LATENCY = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        RW,
   input  logic [1:0]  Size,
   input  logic [7:0]  Address,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        MFC
);
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned VEC_W     = 8;
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned CNT_W     = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic        rw;
      logic [1:0]  size;
      logic [7:0]  addr;
      logic [31:0] data;
   } req_t;

   state_t                            state, state_nxt;
   req_t                              req;
   logic [CNT_W-1:0]                  cnt;
   logic                              access;
   logic [NUM_LANES-1:0]              lane_we;
   logic [NUM_LANES-1:0][VEC_W-1:0]   lane_wd;
   logic [NUM_LANES-1:0][VEC_W-1:0]   lane_rd;
   logic [31:0]                       rd_word;

   // The access commits on the last BUSY cycle; Reset on that edge aborts it.
   assign access = (state == BUSY) && (cnt == '0) && !Reset;

   always_ff @(posedge CLK) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!Enable)     state_nxt = BUSY;
         BUSY:    if (cnt == '0)   state_nxt = DONE;
         DONE:    if (Enable)      state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         cnt <= '0;
         req <= '0;
      end else begin
         case (state)
            IDLE: if (!Enable) begin
               req <= '{rw: RW, size: Size, addr: Address, data: DataIn};
               cnt <= CNT_W'(LATENCY - 1);
            end
            BUSY: if (cnt != '0) cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // Lane k holds bytes whose address has [1:0] == k, so lane 0 is the MSB of a word.
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic sel;
      always_comb begin
         sel        = 1'b0;
         lane_wd[k] = '0;
         case (req.size)
            SZ_BYTE: begin
               sel        = (req.addr[1:0] == 2'(k));
               lane_wd[k] = req.data[7:0];
            end
            SZ_HALF: begin
               sel        = (req.addr[1] == k[1]);
               lane_wd[k] = k[0] ? req.data[7:0] : req.data[15:8];
            end
            SZ_WORD: begin
               sel        = 1'b1;
               lane_wd[k] = req.data[VEC_W*(NUM_LANES-1-k) +: VEC_W];
            end
            default: ;
         endcase
      end
      assign lane_we[k] = access && req.rw && sel;

      data_memory_lane #(.IDX_W(IDX_W), .VEC_W(VEC_W)) u_lane (
         .CLK (CLK),
         .we  (lane_we[k]),
         .idx (req.addr[7:2]),
         .wd  (lane_wd[k]),
         .rd  (lane_rd[k])
      );
   end

   always_comb begin
      rd_word = '0;
      case (req.size)
         SZ_BYTE: rd_word[7:0]  = lane_rd[req.addr[1:0]];
         SZ_HALF: rd_word[15:0] = {lane_rd[{req.addr[1], 1'b0}], lane_rd[{req.addr[1], 1'b1}]};
         SZ_WORD: rd_word       = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
         default: rd_word       = '0;
      endcase
   end

   // Reserved size clears DataOut whether read or write; normal writes leave it alone.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         DataOut <= '0;
         MFC     <= 1'b0;
      end else begin
         MFC <= (state_nxt == DONE);
         if (access) begin
            if (req.size == 2'b11) DataOut <= '0;
            else if (!req.rw)      DataOut <= rd_word;
         end
      end
   end
endmodule
